// File: rtl/fesitel_decrypt.sv
// fesitel_decrypt: iterative 4x16-bit Feistel-style block decryptor, one inverse round per cycle,
// with key whitening on accept and a valid/ready handshake on both sides.
module fesitel_decrypt #(
    parameter int ROUNDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [0:63] ct,
    input  logic [0:31] tt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:63] pt,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [0:63] st;
    logic [0:63] inv;
    logic        last;

    assign last = cnt == 5'(ROUNDS - 1);
    // {w0,w1,w2,w3} -> {w3, w0^w3, w1, w2^w1}
    assign inv = {st[48:63], st[0:15] ^ st[48:63], st[16:31], st[32:47] ^ st[16:31]};

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    assign pt        = st;

    always_comb begin
        state_nxt = state;
        if (state == IDLE && in_valid)
            state_nxt = RUN;
        else if (state == RUN && last)
            state_nxt = DONE;
        else if (state == DONE && out_ready)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            st    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                st  <= ct ^ {tt, tt};
                cnt <= '0;
            end else if (state == RUN) begin
                st  <= inv;
                cnt <= cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_fesitel_decrypt.sv
// tb_fesitel_decrypt: randomized self-checking bench for fesitel_decrypt (ROUNDS=8 and ROUNDS=1),
// expected plaintexts come from encrypting with the forward round.
module tb_fesitel_decrypt;
    logic        clk = 0;
    logic        rst_n;
    logic        iv8, ir8, ov8, or8, busy8;
    logic [63:0] ct8, pt8;
    logic [31:0] tt8;
    logic        iv1, ir1, ov1, or1, busy1;
    logic [63:0] ct1, pt1;
    logic [31:0] tt1;
    int          n_tests = 0;
    int          n_fail = 0;

    fesitel_decrypt #(.ROUNDS(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .ct(ct8), .tt(tt8),
        .out_valid(ov8), .out_ready(or8), .pt(pt8), .busy(busy8)
    );

    fesitel_decrypt #(.ROUNDS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .ct(ct1), .tt(tt1),
        .out_valid(ov1), .out_ready(or1), .pt(pt1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Forward round applied eight times, then whitening with {tt,tt}.
    function automatic logic [63:0] enc(input logic [63:0] p, input logic [31:0] t);
        logic [15:0] w[4];
        logic [15:0] n[4];
        for (int i = 0; i < 4; i++) w[i] = p[63-16*i -: 16];
        repeat (8) begin
            n[0] = w[0] ^ w[1];
            n[1] = w[2];
            n[2] = w[2] ^ w[3];
            n[3] = w[0];
            w = n;
        end
        return {w[0] ^ t[31:16], w[1] ^ t[15:0], w[2] ^ t[31:16], w[3] ^ t[15:0]};
    endfunction

    task automatic block8(input logic [63:0] p0, input logic [31:0] t);
        int lat = 0;
        iv8 = 1; ct8 = enc(p0, t); tt8 = t; or8 = 1;
        check("rnd_ready", {63'd0, ir8}, 64'd1);
        tick;
        iv8 = 0; ct8 = {$urandom, $urandom}; tt8 = $urandom;
        while (!ov8 && lat < 40) begin
            tick;
            lat++;
        end
        check("rnd_latency", 64'(lat), 64'd8);
        check("rnd_pt", pt8, p0);
        tick;
    endtask

    initial begin
        logic [63:0] p;
        logic [31:0] t;
        logic [63:0] q[$];
        int          ov_seen, last_acc, cyc;
        logic        acc;
        rst_n = 1;
        iv8 = 0; ct8 = 0; tt8 = 0; or8 = 0;
        iv1 = 0; ct1 = 0; tt1 = 0; or1 = 0;
        #2 rst_n = 0;
        #1;
        check("rst_in_ready", {63'd0, ir8}, 64'd1);
        check("rst_out_valid", {63'd0, ov8}, 64'd0);
        check("rst_busy", {63'd0, busy8}, 64'd0);
        check("rst_pt", pt8, 64'd0);
        tick;
        rst_n = 1;

        // ROUNDS=1 directed vectors; the first is accepted on the first edge after release
        iv1 = 1; ct1 = 64'h0001_0002_0003_0004; tt1 = 32'h0; or1 = 1;
        tick;
        iv1 = 0;
        check("r1_busy_after_accept", {63'd0, busy1}, 64'd1);
        check("r1_ov_early", {63'd0, ov1}, 64'd0);
        tick;
        check("r1_ov", {63'd0, ov1}, 64'd1);
        check("r1_pt_tt0", pt1, 64'h0004_0005_0002_0001);
        tick;
        check("r1_idle", {63'd0, ir1}, 64'd1);
        iv1 = 1; tt1 = 32'h0001_0001;
        tick;
        iv1 = 0;
        tick;
        check("r1_ov2", {63'd0, ov1}, 64'd1);
        check("r1_pt_tt", pt1, 64'h0005_0005_0003_0001);
        tick;

        for (int i = 0; i < 1000; i++) block8({$urandom, $urandom}, $urandom);

        // Backpressure in DONE with new input offered
        p = {$urandom, $urandom}; t = $urandom;
        iv8 = 1; ct8 = enc(p, t); tt8 = t; or8 = 0;
        tick;
        iv8 = 0;
        repeat (8) tick;
        check("bp_ov", {63'd0, ov8}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            iv8 = 1; ct8 = {$urandom, $urandom}; tt8 = $urandom;
            tick;
            check("bp_pt_stable", pt8, p);
            check("bp_in_ready", {63'd0, ir8}, 64'd0);
            check("bp_ov_held", {63'd0, ov8}, 64'd1);
        end
        or8 = 1;
        tick;
        iv8 = 0;
        check("bp_release_ready", {63'd0, ir8}, 64'd1);
        check("bp_release_ov", {63'd0, ov8}, 64'd0);

        // Reset pulse at round 4 of 8
        p = {$urandom, $urandom}; t = $urandom;
        iv8 = 1; ct8 = enc(p, t); tt8 = t;
        tick;
        iv8 = 0;
        repeat (4) tick;
        rst_n = 0;
        #1;
        check("mid_rst_in_ready", {63'd0, ir8}, 64'd1);
        check("mid_rst_ov", {63'd0, ov8}, 64'd0);
        check("mid_rst_busy", {63'd0, busy8}, 64'd0);
        check("mid_rst_pt", pt8, 64'd0);
        tick;
        rst_n = 1;
        ov_seen = 0;
        repeat (15) begin
            tick;
            if (ov8) ov_seen++;
        end
        check("mid_rst_no_ov", 64'(ov_seen), 64'd0);
        block8({$urandom, $urandom}, $urandom);

        // Back-to-back with in_valid and out_ready held high
        iv8 = 1; or8 = 1; last_acc = -1; cyc = 0;
        repeat (55) begin
            acc = ir8;
            if (acc) begin
                p = {$urandom, $urandom}; t = $urandom;
                ct8 = enc(p, t); tt8 = t;
                q.push_back(p);
            end
            tick;
            cyc++;
            if (acc) begin
                if (last_acc >= 0) check("b2b_gap", 64'(cyc - last_acc), 64'd10);
                last_acc = cyc;
            end
            if (ov8) begin
                check("b2b_pt", pt8, q.size() > 0 ? q[0] : 64'hx);
                if (q.size() > 0) void'(q.pop_front());
            end
        end
        iv8 = 0;
        check("b2b_drained", 64'(q.size()), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
